// File: rtl/font_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : font_fetch_arbiter
// Description : Shares one registered-read font ROM between a display pixel
//               shifter (priority) and a CPU byte-read port.
// Revision    : 1.0 - initial release
// ============================================================================
module font_fetch_arbiter #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_load,
    input  logic [7:0]  disp_char,
    input  logic [3:0]  disp_row,
    input  logic        disp_invert,
    output logic        pixel_on,
    output logic        pixel_valid,
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_ACK  = 2'd2
    } cpu_state_t;

    cpu_state_t  state_q, state_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [11:0] last_addr_q, last_addr_d;
    logic        rd_vld_q, rd_vld_d;
    logic        rd_disp_q, rd_disp_d;
    logic        inv_q, inv_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        cpu_issue;
    logic        pix_bit;
    logic [7:0]  shift_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign pix_bit    = shift_q[7];
            assign shift_next = {shift_q[6:0], 1'b0};
        end else begin : g_lsb_first
            assign pix_bit    = shift_q[0];
            assign shift_next = {1'b0, shift_q[7:1]};
        end
    endgenerate

    assign cpu_issue = ~disp_load & cpu_req & (state_q == S_IDLE);

    // Display wins the single ROM port; idle cycles keep presenting the last address.
    always_comb begin
        rom_addr = last_addr_q;
        if (rst) begin
            rom_addr = 12'd0;
        end else if (disp_load) begin
            rom_addr = {disp_char, disp_row};
        end else if (cpu_issue) begin
            rom_addr = cpu_addr;
        end
    end

    always_comb begin
        last_addr_d = rom_addr;
        rd_vld_d    = disp_load | cpu_issue;
        rd_disp_d   = disp_load;
        inv_d       = disp_load ? disp_invert : inv_q;

        state_d    = state_q;
        cpu_data_d = cpu_data_q;
        cpu_ack_d  = 1'b0;
        case (state_q)
            S_IDLE: if (cpu_issue) state_d = S_RD;
            S_RD: begin
                state_d   = S_ACK;
                cpu_ack_d = 1'b1;
                if (rd_vld_q && !rd_disp_q) cpu_data_d = rom_dout;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (rd_vld_q && rd_disp_q) begin
            shift_d = rom_dout ^ {8{inv_q}};
            cnt_d   = 4'd8;
        end else if (cnt_q != 4'd0) begin
            shift_d = shift_next;
            cnt_d   = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cpu_data_q  <= 8'd0;
            cpu_ack_q   <= 1'b0;
            last_addr_q <= 12'd0;
            rd_vld_q    <= 1'b0;
            rd_disp_q   <= 1'b0;
            inv_q       <= 1'b0;
            shift_q     <= 8'd0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cpu_data_q  <= cpu_data_d;
            cpu_ack_q   <= cpu_ack_d;
            last_addr_q <= last_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_disp_q   <= rd_disp_d;
            inv_q       <= inv_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_data    = cpu_data_q;
    assign pixel_valid = (cnt_q != 4'd0);
    assign pixel_on    = pixel_valid & pix_bit;

endmodule
`default_nettype wire

// File: tb/tb_font_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_font_fetch_arbiter
// Description : Scoreboard bench for font_fetch_arbiter with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_font_fetch_arbiter;

    localparam bit C_MSB_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_load = 1'b0;
    logic [7:0]  disp_char = 8'd0;
    logic [3:0]  disp_row = 4'd0;
    logic        disp_invert = 1'b0;
    logic        pixel_on, pixel_valid;
    logic        cpu_req = 1'b0;
    logic [11:0] cpu_addr = 12'd0;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic [11:0] rom_addr;
    logic [7:0]  rom_dout = 8'd0;

    always #5 clk = ~clk;

    font_fetch_arbiter #(.MSB_FIRST(C_MSB_FIRST)) dut (
        .clk(clk), .rst(rst),
        .disp_load(disp_load), .disp_char(disp_char), .disp_row(disp_row),
        .disp_invert(disp_invert),
        .pixel_on(pixel_on), .pixel_valid(pixel_valid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        int v;
        if (a == 12'h413) return 8'h18;
        if (a == 12'h7FF) return 8'hA5;
        v = int'(a) * 37 + int'(a >> 5) + 11;
        return v[7:0];
    endfunction

    // Font ROM with one-cycle registered read
    always @(posedge clk) rom_dout <= rom_f(rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: expected pixel per cycle, expected CPU acks, address tracking
    bit exp_v [0:8191];
    bit exp_p [0:8191];
    typedef struct { int cyc; logic [7:0] data; } cpu_exp_t;
    cpu_exp_t    cq[$];
    logic [11:0] m_last = 12'd0;
    int          m_issue = -100;

    task automatic cycle(input bit rs, input bit dl, input logic [7:0] ch, input logic [3:0] rw,
                         input bit inv, input bit rq, input logic [11:0] ad, output bit issued);
        logic [11:0] ea;
        logic [7:0]  b;
        @(posedge clk);
        #1;
        rst = rs; disp_load = dl; disp_char = ch; disp_row = rw; disp_invert = inv;
        cpu_req = rq; cpu_addr = ad;
        issued = 1'b0;
        if (rs) begin
            ea = 12'd0;
            m_last = 12'd0;
            m_issue = -100;
            for (int k = cyc + 1; k < cyc + 12; k++) begin
                exp_v[k] = 1'b0;
                exp_p[k] = 1'b0;
            end
            while (cq.size() > 0 && cq[$].cyc > cyc) void'(cq.pop_back());
        end else if (dl) begin
            ea = {ch, rw};
            m_last = ea;
            b = rom_f(ea) ^ {8{inv}};
            for (int k = 0; k < 8; k++) begin
                exp_v[cyc + 2 + k] = 1'b1;
                exp_p[cyc + 2 + k] = C_MSB_FIRST ? b[7 - k] : b[k];
            end
        end else if (rq && cyc >= m_issue + 3) begin
            ea = ad;
            m_last = ea;
            m_issue = cyc;
            cq.push_back('{cyc + 2, rom_f(ad)});
            issued = 1'b1;
        end else begin
            ea = m_last;
        end
        @(negedge clk);
        chk("rom_addr", 32'(rom_addr), 32'(ea));
    endtask

    task automatic idle(input int n);
        bit is;
        repeat (n) cycle(0, 0, 8'd0, 4'd0, 0, 0, 12'd0, is);
    endtask

    // Monitor: pixel stream per cycle and CPU acks popped from the scoreboard
    always @(negedge clk) begin
        if (cyc >= 2) begin
            chk("pixel_valid", 32'(pixel_valid), 32'(exp_v[cyc]));
            chk("pixel_on", 32'(pixel_on), exp_v[cyc] ? 32'(exp_p[cyc]) : 32'd0);
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL cpu_ack_missing: ack required at cycle %0d was absent", cq[0].cyc);
                void'(cq.pop_front());
            end
            if (cpu_ack) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_ack_spurious @cycle %0d: got ack=1 required ack=0", cyc);
                end else begin
                    cpu_exp_t e;
                    e = cq.pop_front();
                    chk("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("cpu_data", 32'(cpu_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        bit          is;
        bit          dl, req_on;
        int          last_dl, ack_at, nc;
        logic [11:0] raddr;
        logic [7:0]  rch;
        logic [3:0]  rrw;
        bit          rinv;

        repeat (3) cycle(1, 0, 8'd0, 4'd0, 0, 0, 12'd0, is);
        chk("rst_cpu_data", 32'(cpu_data), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        idle(2);

        // Plain and inverted glyph rows
        cycle(0, 1, 8'h41, 4'h3, 0, 0, 12'd0, is);
        idle(10);
        cycle(0, 1, 8'h41, 4'h3, 1, 0, 12'd0, is);
        idle(10);

        // CPU read with no display traffic
        cycle(0, 0, 8'd0, 4'd0, 0, 1, 12'h7FF, is);
        repeat (2) cycle(0, 0, 8'd0, 4'd0, 0, 1, 12'h7FF, is);
        idle(3);
        chk("cpu_data_hold", 32'(cpu_data), 32'hA5);

        // CPU request colliding with a display load
        cycle(0, 1, 8'h52, 4'h7, 0, 1, 12'h123, is);
        repeat (3) cycle(0, 0, 8'd0, 4'd0, 0, 1, 12'h123, is);
        idle(10);

        // Second display load while the first row is still shifting
        cycle(0, 1, 8'h30, 4'h5, 0, 0, 12'd0, is);
        idle(3);
        cycle(0, 1, 8'h31, 4'h9, 1, 0, 12'd0, is);
        idle(12);

        // Reset right after a CPU issue; requests during reset are ignored
        cycle(0, 0, 8'd0, 4'd0, 0, 1, 12'h234, is);
        cycle(1, 1, 8'h41, 4'h3, 0, 1, 12'h7FF, is);
        cycle(0, 0, 8'd0, 4'd0, 0, 0, 12'd0, is);
        chk("post_rst_cpu_data", 32'(cpu_data), 32'd0);
        chk("post_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("post_rst_pixel_valid", 32'(pixel_valid), 32'd0);
        idle(3);
        repeat (3) cycle(0, 0, 8'd0, 4'd0, 0, 1, 12'h456, is);
        idle(4);

        // Randomized mixed traffic, display loads spaced at least 2 cycles apart
        last_dl = -10;
        req_on  = 1'b0;
        ack_at  = -1;
        raddr   = 12'd0;
        for (int n = 0; n < 600; n++) begin
            nc = cyc + 1;
            if (req_on && ack_at >= 0 && nc > ack_at) begin
                req_on = 1'b0;
                ack_at = -1;
            end
            if (!req_on && $urandom_range(0, 2) == 0) begin
                req_on = 1'b1;
                raddr  = 12'($urandom);
            end
            dl = (nc - last_dl >= 2) && ($urandom_range(0, 3) == 0);
            if (dl) last_dl = nc;
            rch  = 8'($urandom);
            rrw  = 4'($urandom);
            rinv = 1'($urandom);
            cycle(0, dl, rch, rrw, rinv, req_on, raddr, is);
            if (is) ack_at = nc + 2;
        end
        idle(14);
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
